// File: rtl/wb_writeback_pkg.sv
// Shared definitions for the write-back stage: write-data select codes,
// FSM state encoding and the load-classification helper.
package wb_writeback_pkg;

    // Write-data select codes carried with each retiring instruction.
    localparam logic [1:0] RF_WSEL_ALUC = 2'd0;
    localparam logic [1:0] RF_WSEL_RDO  = 2'd1;
    localparam logic [1:0] RF_WSEL_PC4  = 2'd2;
    localparam logic [1:0] RF_WSEL_EXT  = 2'd3;

    // Write-back sequencer states.
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_REQ   = 2'd1,
        WB_WAIT  = 2'd2,
        WB_WRITE = 2'd3
    } wb_state_e;

    // An instruction needs DRAM only when it both writes the RF and selects read data.
    function automatic logic wb_is_load(input logic rf_we, input logic [1:0] wsel);
        return rf_we && (wsel == RF_WSEL_RDO);
    endfunction

endpackage

// File: rtl/wb_writeback.sv
// Write-back stage: accepts one retiring instruction at a time from execute,
// fetches load data from DRAM when needed and drives the single RF write port.
// The pending destination register is exposed so decode can stall on RAW hazards.
module wb_writeback
    import wb_writeback_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_rf_we,
    input  logic [1:0]    in_rf_wsel,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_aluc,
    input  logic [DW-1:0] in_pc4,
    input  logic [DW-1:0] in_ext,
    output logic          dram_re,
    output logic [DW-1:0] dram_addr,
    input  logic          dram_gnt,
    input  logic          dram_rvalid,
    input  logic [DW-1:0] dram_rdo,
    output logic          rf_we,
    output logic [RW-1:0] rf_wr,
    output logic [DW-1:0] rf_wd,
    output logic [RW-1:0] busy_rd
);

    wb_state_e     r_state;
    wb_state_e     w_state_nxt;

    // Fields of the accepted instruction still needed after the accept cycle.
    logic [RW-1:0] r_rd;
    logic          r_we;
    logic [DW-1:0] r_aluc;

    // Registered outputs and their next values.
    logic          r_dram_re;
    logic [DW-1:0] r_dram_addr;
    logic          r_rf_we;
    logic [RW-1:0] r_rf_wr;
    logic [DW-1:0] r_rf_wd;
    logic          w_dram_re_nxt;
    logic [DW-1:0] w_dram_addr_nxt;
    logic          w_rf_we_nxt;
    logic [RW-1:0] w_rf_wr_nxt;
    logic [DW-1:0] w_rf_wd_nxt;

    logic          w_accept;
    logic          w_load;
    logic          w_dram_done;
    logic [DW-1:0] w_mux_data;

    assign in_ready    = (r_state == WB_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_load      = wb_is_load(in_rf_we, in_rf_wsel);
    // Read data is taken on rvalid, either together with the grant or later while waiting.
    assign w_dram_done = ((r_state == WB_REQ) && dram_gnt && dram_rvalid) ||
                         ((r_state == WB_WAIT) && dram_rvalid);

    assign dram_re   = r_dram_re;
    assign dram_addr = r_dram_addr;
    assign rf_we     = r_rf_we;
    assign rf_wr     = r_rf_wr;
    assign rf_wd     = r_rf_wd;

    // Non-load write data is selected at accept so WRITE follows one cycle later.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_mux_data = in_aluc;
        case (in_rf_wsel)
            RF_WSEL_ALUC: w_mux_data = in_aluc;
            RF_WSEL_PC4:  w_mux_data = in_pc4;
            RF_WSEL_EXT:  w_mux_data = in_ext;
            default:      w_mux_data = in_aluc;
        endcase
    end

    // State register and registered outputs; reset drops any in-flight load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WB_IDLE;
            r_dram_re   <= 1'b0;
            r_dram_addr <= '0;
            r_rf_we     <= 1'b0;
            r_rf_wr     <= '0;
            r_rf_wd     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_dram_re   <= w_dram_re_nxt;
            r_dram_addr <= w_dram_addr_nxt;
            r_rf_we     <= w_rf_we_nxt;
            r_rf_wr     <= w_rf_wr_nxt;
            r_rf_wd     <= w_rf_wd_nxt;
        end
    end

    // Capture the instruction fields needed beyond the accept cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd   <= '0;
            r_we   <= 1'b0;
            r_aluc <= '0;
        end else if (w_accept) begin
            r_rd   <= in_rd;
            r_we   <= in_rf_we;
            r_aluc <= in_aluc;
        end
    end

    // Next-state logic: loads go through DRAM, everything else straight to WRITE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_load ? WB_REQ : WB_WRITE;
                end
            end
            WB_REQ: begin
                if (dram_gnt) begin
                    w_state_nxt = dram_rvalid ? WB_WRITE : WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (dram_rvalid) begin
                    w_state_nxt = WB_WRITE;
                end
            end
            WB_WRITE: w_state_nxt = WB_IDLE;
            default:  w_state_nxt = WB_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, plus the hazard index.
    always_comb begin
        w_dram_re_nxt   = 1'b0;
        w_dram_addr_nxt = '0;
        w_rf_we_nxt     = 1'b0;
        w_rf_wr_nxt     = '0;
        w_rf_wd_nxt     = '0;
        busy_rd         = '0;

        if ((r_state != WB_IDLE) && r_we) begin
            busy_rd = r_rd;
        end

        case (r_state)
            WB_IDLE: begin
                if (w_accept) begin
                    if (w_load) begin
                        w_dram_re_nxt   = 1'b1;
                        w_dram_addr_nxt = in_aluc;
                    end else begin
                        // Register 0 is hard-wired; the write is suppressed, not the sequence.
                        w_rf_we_nxt = in_rf_we && (in_rd != '0);
                        w_rf_wr_nxt = in_rd;
                        w_rf_wd_nxt = w_mux_data;
                    end
                end
            end
            WB_REQ: begin
                // Request and address stay put until DRAM grants.
                if (!dram_gnt) begin
                    w_dram_re_nxt   = 1'b1;
                    w_dram_addr_nxt = r_aluc;
                end
            end
            default: ;
        endcase

        if (w_dram_done) begin
            w_rf_we_nxt = r_we && (r_rd != '0);
            w_rf_wr_nxt = r_rd;
            w_rf_wd_nxt = dram_rdo;
        end
    end

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level model of the stage.
module tb_wb_writeback;
    import wb_writeback_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_rf_we;
    logic [1:0]    in_rf_wsel;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_aluc;
    logic [DW-1:0] in_pc4;
    logic [DW-1:0] in_ext;
    logic          dram_re;
    logic [DW-1:0] dram_addr;
    logic          dram_gnt;
    logic          dram_rvalid;
    logic [DW-1:0] dram_rdo;
    logic          rf_we;
    logic [RW-1:0] rf_wr;
    logic [DW-1:0] rf_wd;
    logic [RW-1:0] busy_rd;

    always #5 clk = ~clk;

    wb_writeback #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rf_we    (in_rf_we),
        .in_rf_wsel  (in_rf_wsel),
        .in_rd       (in_rd),
        .in_aluc     (in_aluc),
        .in_pc4      (in_pc4),
        .in_ext      (in_ext),
        .dram_re     (dram_re),
        .dram_addr   (dram_addr),
        .dram_gnt    (dram_gnt),
        .dram_rvalid (dram_rvalid),
        .dram_rdo    (dram_rdo),
        .rf_we       (rf_we),
        .rf_wr       (rf_wr),
        .rf_wd       (rf_wd),
        .busy_rd     (busy_rd)
    );

    // One instruction offered by execute; g = cycles DRAM withholds the grant,
    // r = cycles from grant to read data, gap = idle cycles before it is offered.
    typedef struct {
        logic          we;
        logic [1:0]    wsel;
        logic [RW-1:0] rd;
        logic [DW-1:0] aluc;
        logic [DW-1:0] pc4;
        logic [DW-1:0] ext;
        int            g;
        int            r;
        int            gap;
    } instr_t;

    // Expected observable behaviour of one accepted instruction.
    typedef struct {
        int            acc;
        int            due;
        logic          is_load;
        int            g;
        logic          writes;
        logic [RW-1:0] busy;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [DW-1:0] addr;
    } exp_t;

    typedef struct {
        int g;
        int r;
    } dcfg_t;

    instr_t stim_q[$];
    exp_t   sb_q[$];
    dcfg_t  dcfg_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Contents of the DRAM model: a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_data(input logic [DW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F5A;
    endfunction

    // DRAM responder: grant after g cycles, read data r cycles after the grant.
    int            d_phase = 0;
    int            d_gcnt  = 0;
    int            d_rcnt  = 0;
    logic [DW-1:0] d_addr  = '0;
    always @(negedge clk) begin : dram_model
        dcfg_t c;
        dram_gnt    = 1'b0;
        dram_rvalid = 1'b0;
        dram_rdo    = $urandom();
        if (d_phase == 0 && dram_re && dcfg_q.size() > 0) begin
            c       = dcfg_q.pop_front();
            d_gcnt  = c.g;
            d_rcnt  = c.r;
            d_addr  = dram_addr;
            d_phase = 1;
        end
        if (d_phase == 1) begin
            if (d_gcnt == 0) begin
                dram_gnt = 1'b1;
                if (d_rcnt == 0) begin
                    dram_rvalid = 1'b1;
                    dram_rdo    = mem_data(d_addr);
                    d_phase     = 0;
                end else begin
                    d_phase = 2;
                end
            end else begin
                d_gcnt--;
            end
        end else if (d_phase == 2) begin
            d_rcnt--;
            if (d_rcnt == 0) begin
                dram_rvalid = 1'b1;
                dram_rdo    = mem_data(d_addr);
                d_phase     = 0;
            end
        end
    end

    // What retiring this instruction should look like from outside.
    function automatic exp_t model(input instr_t s, input int acc);
        exp_t e;
        e.acc     = acc;
        e.is_load = s.we && (s.wsel == RF_WSEL_RDO);
        e.g       = s.g;
        e.writes  = s.we && (s.rd != 0);
        e.busy    = s.we ? s.rd : '0;
        e.rd      = s.rd;
        e.addr    = s.aluc;
        e.due     = e.is_load ? acc + 2 + s.g + s.r : acc + 1;
        case (s.wsel)
            RF_WSEL_PC4: e.data = s.pc4;
            RF_WSEL_EXT: e.data = s.ext;
            RF_WSEL_RDO: e.data = e.is_load ? mem_data(s.aluc) : s.aluc;
            default:     e.data = s.aluc;
        endcase
        return e;
    endfunction

    // One clock cycle: check every output against the model, then drive execute.
    task automatic step();
        exp_t   e;
        instr_t s;
        bit     busy;
        logic [RW-1:0] exp_busy;
        logic   exp_re;
        @(negedge clk);
        cyc++;
        busy     = (sb_q.size() > 0);
        exp_busy = '0;
        exp_re   = 1'b0;
        if (busy) begin
            e        = sb_q[0];
            exp_busy = e.busy;
            exp_re   = e.is_load && (cyc >= e.acc + 1) && (cyc <= e.acc + 1 + e.g);
        end
        check("in_ready", in_ready, !busy);
        check("busy_rd", busy_rd, exp_busy);
        check("dram_re", dram_re, exp_re);
        if (exp_re) check("dram_addr", dram_addr, e.addr);
        if (busy && e.due == cyc) begin
            check("rf_we", rf_we, e.writes);
            if (e.writes) begin
                check("rf_wr", rf_wr, e.rd);
                check("rf_wd", rf_wd, e.data);
            end
            void'(sb_q.pop_front());
        end else begin
            check("rf_we_quiet", rf_we, 1'b0);
        end

        in_valid   = 1'b0;
        in_rf_we   = 1'($urandom());
        in_rf_wsel = 2'($urandom());
        in_rd      = RW'($urandom());
        in_aluc    = $urandom();
        in_pc4     = $urandom();
        in_ext     = $urandom();
        if (stim_q.size() > 0) begin
            s = stim_q[0];
            if (s.gap > 0) begin
                s.gap--;
                stim_q[0] = s;
            end else begin
                in_valid   = 1'b1;
                in_rf_we   = s.we;
                in_rf_wsel = s.wsel;
                in_rd      = s.rd;
                in_aluc    = s.aluc;
                in_pc4     = s.pc4;
                in_ext     = s.ext;
                if (!busy) begin
                    void'(stim_q.pop_front());
                    e = model(s, cyc);
                    sb_q.push_back(e);
                    if (e.is_load) dcfg_q.push_back('{g: s.g, r: s.r});
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_drained"}, (stim_q.size() + sb_q.size()) == 0, 1'b1);
    endtask

    task automatic push(input logic we, input logic [1:0] wsel, input logic [RW-1:0] rd,
                        input logic [DW-1:0] aluc, input logic [DW-1:0] pc4,
                        input logic [DW-1:0] ext, input int g, input int r, input int gap);
        stim_q.push_back('{we: we, wsel: wsel, rd: rd, aluc: aluc, pc4: pc4, ext: ext,
                           g: g, r: r, gap: gap});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_dram_re"}, dram_re, 1'b0);
        check({tag, "_dram_addr"}, dram_addr, '0);
        check({tag, "_rf_we"}, rf_we, 1'b0);
        check({tag, "_rf_wr"}, rf_wr, '0);
        check({tag, "_rf_wd"}, rf_wd, '0);
        check({tag, "_busy_rd"}, busy_rd, '0);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_rf_we   = 1'b0;
        in_rf_wsel = RF_WSEL_ALUC;
        in_rd      = '0;
        in_aluc    = '0;
        in_pc4     = '0;
        in_ext     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // ALU op writes back the next cycle.
        push(1'b1, RF_WSEL_ALUC, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
        drain("alu");
        // Load with grant and data together.
        push(1'b1, RF_WSEL_RDO, 5'd7, 32'h40, 32'h0, 32'h0, 0, 0, 1);
        drain("load_fast");
        // Load with slow grant and slow data.
        push(1'b1, RF_WSEL_RDO, 5'd9, 32'h88, 32'h0, 32'h0, 2, 2, 1);
        drain("load_slow");
        // JAL to x0: full sequence, no write.
        push(1'b1, RF_WSEL_PC4, 5'd0, 32'h0, 32'h104, 32'h0, 0, 0, 1);
        drain("jal_x0");
        // Load to x0 still reads DRAM; non-writing RDO never touches DRAM.
        push(1'b1, RF_WSEL_RDO, 5'd0, 32'h3C, 32'h0, 32'h0, 1, 1, 0);
        push(1'b0, RF_WSEL_RDO, 5'd3, 32'h50, 32'h0, 32'h0, 0, 0, 0);
        push(1'b1, RF_WSEL_EXT, 5'd31, 32'h0, 32'h0, 32'hFFFF_F800, 0, 0, 0);
        drain("corner");
        // Back-to-back ALU ops with valid held.
        push(1'b1, RF_WSEL_ALUC, 5'd1, 32'h11, 32'h0, 32'h0, 0, 0, 0);
        push(1'b1, RF_WSEL_ALUC, 5'd2, 32'h22, 32'h0, 32'h0, 0, 0, 0);
        push(1'b1, RF_WSEL_ALUC, 5'd3, 32'h33, 32'h0, 32'h0, 0, 0, 0);
        drain("b2b");

        // Reset while waiting for read data; the late rvalid must be ignored.
        push(1'b1, RF_WSEL_RDO, 5'd12, 32'hA0, 32'h0, 32'h0, 0, 4, 0);
        while (stim_q.size() > 0) step();
        step();
        step();
        check("wait_busy_rd", busy_rd, 5'd12);
        rst = 1'b0;
        sb_q.delete();
        dcfg_q.delete();
        #1;
        check_idle_outputs("rst_wait");
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (6) step();
        check_idle_outputs("after_rst");

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            push(($urandom_range(0, 9) != 0), 2'($urandom()),
                 ($urandom_range(0, 5) == 0) ? 5'd0 : RW'($urandom()),
                 $urandom(), $urandom(), $urandom(),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
